// File: rtl/wvfm_loader.sv
// rtl/wvfm_loader.sv - waveform LUT loader: streams host bytes into LUT port A during vblank
module wvfm_loader #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [ABITS-1:0] load_base,
  input  logic [ABITS:0]   load_len,
  input  logic             load_abort,
  input  logic             s_valid,
  input  logic [DBITS-1:0] s_data,
  output logic             s_ready,
  input  logic             vblank,
  output logic             lut_we,
  output logic [ABITS-1:0] lut_addr,
  output logic [DBITS-1:0] lut_din,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      csum
);

  typedef enum logic [1:0] {IDLE, WAIT_VB, WRITE, FINISH} state_t;

  state_t           state;
  logic [ABITS-1:0] addr;
  logic [ABITS:0]   remaining;
  logic             hs;

  // Ready drops combinationally with vblank so no byte is accepted while port A is shared.
  assign s_ready = (state == WRITE) && vblank && (remaining != '0);
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      lut_we    <= 1'b0;
      lut_addr  <= '0;
      lut_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      csum      <= '0;
    end else begin
      lut_we <= 1'b0;
      done   <= 1'b0;

      // A byte accepted in an abort cycle is still written and summed.
      if (hs) begin
        lut_we    <= 1'b1;
        lut_addr  <= addr;
        lut_din   <= s_data;
        csum      <= csum + 16'(s_data);
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_start) begin
            addr      <= load_base;
            remaining <= load_len;
            csum      <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= (load_len == '0) ? FINISH : WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (load_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
          end else if (vblank) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (load_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
          end else if (hs && (remaining == (ABITS+1)'(1))) begin
            state <= FINISH;
          end else if (!vblank) begin
            state <= WAIT_VB;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvfm_loader.sv
// tb/tb_wvfm_loader.sv - directed and randomized self-checking bench for wvfm_loader
module tb_wvfm_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [11:0] load_base = '0;
  logic [12:0] load_len = '0;
  logic        load_abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        vblank = 1'b0;
  logic        lut_we;
  logic [11:0] lut_addr;
  logic [7:0]  lut_din;
  logic        busy, done, err;
  logic [15:0] csum;

  wvfm_loader #(.ABITS(12), .DBITS(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .load_abort(load_abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .vblank(vblank), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_din(lut_din), .busy(busy), .done(done),
    .err(err), .csum(csum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what the loader should have done, from the byte-level rules.
  logic [11:0] exp_addr = '0;
  logic [15:0] exp_csum = '0;
  int          exp_rem = 0;
  bit          prev_hs = 0;
  logic [11:0] prev_addr = '0;
  logic [7:0]  prev_byte = '0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  bit          rand_valid = 0;
  bit          rand_vb = 0;
  logic [7:0]  src_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit hs;
    @(negedge clk);
    cyc++;
    if (rst) begin
      prev_hs = 0;
      exp_rem = 0;
    end else begin
      chk("lut_we", lut_we, prev_hs);
      if (prev_hs) begin
        chk("lut_addr", lut_addr, prev_addr);
        chk("lut_din", lut_din, prev_byte);
        last_we_cyc = cyc;
      end
      chk("ready_gate", s_ready && (!vblank || exp_rem == 0), 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hs = s_valid && s_ready;
      if (hs) begin
        prev_addr = exp_addr;
        prev_byte = s_data;
        exp_addr  = exp_addr + 12'd1;
        exp_csum  = exp_csum + 16'(s_data);
        exp_rem--;
        hs_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      prev_hs = hs;
      if (load_abort && busy) exp_rem = 0;
      if (load_start && !busy) begin
        exp_addr = load_base;
        exp_rem  = int'(load_len);
        exp_csum = '0;
        hs_cnt   = 0;
      end
    end
    @(posedge clk);
    #1;
    if (src_q.size() > 0) begin
      s_data  = src_q[0];
      s_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
    if (rand_vb) vblank = ($urandom_range(0, 7) != 0);
  endtask

  task automatic start_load(input logic [11:0] base, input logic [12:0] len);
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - start, 1);
  endtask

  task automatic wait_hs(input int target, input int max, input string tag);
    int n = 0;
    while (hs_cnt < target && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_hs_reached"}, hs_cnt, target);
  endtask

  task automatic normal_load(input string tag);
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    vblank = 1'b1;
    rand_valid = 0;
    start_load(12'h000, 13'd4);
    wait_done(50, tag);
    chk({tag, "_csum"}, csum, 16'h00AA);
    chk({tag, "_hs_cnt"}, hs_cnt, 4);
    chk({tag, "_done_after_we"}, done_cyc, last_we_cyc + 1);
    chk({tag, "_last_addr"}, lut_addr, 12'h003);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int d0;
    logic [11:0] b;
    logic [12:0] l;

    tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_we", lut_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", lut_addr, 0);
    chk("rst_din", lut_din, 0);
    chk("rst_csum", csum, 0);
    rst = 1'b0;
    tick();

    normal_load("normal");

    // wrap-around, with an ignored load_start while busy
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_load(12'hFFE, 13'd4);
    wait_hs(1, 50, "wrap");
    start_load(12'h123, 13'd2);
    wait_done(50, "wrap");
    chk("wrap_csum", csum, 16'h000A);
    chk("wrap_hs_cnt", hs_cnt, 4);
    chk("wrap_last_addr", lut_addr, 12'h001);
    chk("wrap_last_din", lut_din, 8'h04);
    chk("wrap_err", err, 0);

    // vblank gating
    vblank = 1'b0;
    src_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    start_load(12'h200, 13'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gate_ready_low", s_ready, 0);
    end
    chk("gate_no_hs", hs_cnt, 0);
    vblank = 1'b1;
    wait_hs(1, 20, "gate");
    vblank = 1'b0;
    #1;
    chk("gate_ready_drop", s_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("gate_held_hs", hs_cnt, 1);
    chk("gate_busy_held", busy, 1);
    vblank = 1'b1;
    wait_done(50, "gate");
    chk("gate_csum", csum, exp_csum);
    chk("gate_last_addr", lut_addr, 12'h202);

    // zero length
    src_q = '{8'h55};
    d0 = done_cnt;
    start_load(12'h050, 13'd0);
    for (int i = 0; i < 2; i++) begin
      chk("zero_ready", s_ready, 0);
      tick();
    end
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_busy", busy, 0);
    chk("zero_hs", hs_cnt, 0);
    src_q.delete();
    tick();

    // abort after three bytes; simultaneous load_start loses
    rand_valid = 1;
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    start_load(12'h300, 13'd8);
    wait_hs(3, 200, "abort");
    src_q.delete();
    s_valid = 1'b0;
    load_abort = 1'b1;
    load_start = 1'b1;
    d0 = done_cnt;
    tick();
    load_abort = 1'b0;
    load_start = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_single_done", done_cnt - d0, 1);
    chk("abort_writes", hs_cnt, 3);
    chk("abort_csum", csum, exp_csum);
    chk("abort_err_sticky", err, 1);
    chk("abort_start_ignored", busy, 0);
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
    start_load(12'($urandom), 13'd5);
    chk("reload_err_clear", err, 0);
    wait_done(200, "reload");
    chk("reload_csum", csum, exp_csum);
    chk("reload_err", err, 0);

    // async reset mid-write
    rand_valid = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    start_load(12'h400, 13'd8);
    wait_hs(2, 50, "arst");
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", s_ready, 0);
    chk("arst_we", lut_we, 0);
    chk("arst_csum", csum, 0);
    src_q.delete();
    tick();
    rst = 1'b0;
    tick();
    normal_load("post_rst");

    // randomized loads with vblank and valid toggling
    rand_valid = 1;
    rand_vb = 1;
    for (int k = 0; k < 4; k++) begin
      b = 12'($urandom);
      if (k == 0) b = 12'hFF0;
      l = 13'($urandom_range(1, 40));
      for (int i = 0; i < int'(l); i++) src_q.push_back(8'($urandom));
      start_load(b, l);
      wait_done(3000, "rand");
      chk("rand_hs_cnt", hs_cnt, 32'(l));
      chk("rand_csum", csum, exp_csum);
      chk("rand_last_addr", lut_addr, 12'(b + 12'(l) - 12'd1));
      chk("rand_err", err, 0);
      src_q.delete();
      tick();
    end
    rand_vb = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
